data_mem_stall: RTL and testbench

Multi-cycle, stalling data-memory responder on the processor's memory-stage interface. It services 16-bit word reads and writes issued by the memory stage, holding each request for a fixed `LATENCY` cycles before completing. While busy it drives `stall` so the pipeline freezes. It flags misaligned requests on `err`.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/data_mem_stall_if.sv | 25 ++
 rtl/mem_array.sv | 26 ++
 rtl/data_mem_stall.sv | 127 ++++++++++++
 tb/tb_data_mem_stall.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the stalling data-memory responder and its initiators.
// Latency: none (types, constants and a constant function only).
// Backpressure: not applicable.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    // 16-bit word accesses must sit on an even byte address.
    function automatic logic is_misaligned(input logic [15:0] byte_addr);
        return byte_addr[0];
    endfunction

endpackage

// File: rtl/data_mem_stall_if.sv
// Memory-stage request/response bundle between the pipeline and the data memory.
// Latency: none (wires only).
// Backpressure: stall from the responder; initiator holds and re-presents requests.
// Ports: enable/wr/addr/data_in flow initiator->responder;
//        data_out/done/stall/err flow responder->initiator.
interface data_mem_stall_if;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        done;
    logic        stall;
    logic        err;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, done, stall, err
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, done, stall, err
    );
endinterface

// File: rtl/mem_array.sv
// 2^ADDR_W x 16-bit word storage with synchronous write and asynchronous read.
// Latency: write lands at the clock edge; read is combinational.
// Backpressure: none; contents survive reset untouched.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module mem_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);

    logic [15:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_stall.sv
// Stalling data-memory responder: services one 16-bit read/write at a time.
// Latency: LATENCY cycles from acceptance to done for aligned requests, 1 cycle if misaligned.
// Backpressure: stall=1 while BUSY; requests seen while BUSY are dropped and must be re-presented.
// Ports: clk, rst (async, active-high), bus (slave side of data_mem_stall_if).
module data_mem_stall
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    data_mem_stall_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_wr_q, req_wr_d;
    logic                req_err_q, req_err_d;
    logic [ADDR_W-1:0]   req_word_q, req_word_d;
    logic [15:0]         req_data_q, req_data_d;

    logic                accept;
    logic                misaligned;
    logic [ADDR_W-1:0]   in_word;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [15:0]         mem_wdata;
    logic [15:0]         mem_rdata;

    // Address bits above the array size simply alias.
    logic                unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[15:ADDR_W+1];

    assign in_word    = bus.addr[ADDR_W:1];
    assign misaligned = is_misaligned(bus.addr);
    assign accept     = ((state_q == IDLE) || (state_q == DONE)) && bus.enable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_wr_q   <= 1'b0;
            req_err_q  <= 1'b0;
            req_word_q <= '0;
            req_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_wr_q   <= req_wr_d;
            req_err_q  <= req_err_d;
            req_word_q <= req_word_d;
            req_data_q <= req_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_wr_d   = req_wr_q;
        req_err_d  = req_err_q;
        req_word_d = req_word_q;
        req_data_d = req_data_q;
        mem_we     = 1'b0;
        mem_waddr  = req_word_q;
        mem_wdata  = req_data_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (accept) begin
                    req_wr_d   = bus.wr;
                    req_err_d  = misaligned;
                    req_word_d = in_word;
                    req_data_d = bus.data_in;
                    if (misaligned) begin
                        state_d = DONE;
                    end else if (LATENCY == 1) begin
                        // Single-cycle latency: the accepting edge is also the
                        // DONE-entry edge, so commit straight from the bus.
                        state_d   = DONE;
                        mem_we    = bus.wr;
                        mem_waddr = in_word;
                        mem_wdata = bus.data_in;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    // Writes commit only on the edge entering DONE so that a
                    // reset during BUSY leaves the array untouched.
                    state_d = DONE;
                    mem_we  = req_wr_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (req_word_q),
        .rdata (mem_rdata)
    );

    assign bus.done     = (state_q == DONE);
    assign bus.stall    = (state_q == BUSY);
    assign bus.err      = (state_q == DONE) && req_err_q;
    assign bus.data_out = ((state_q == DONE) && !req_wr_q && !req_err_q) ? mem_rdata : 16'h0000;

endmodule

// File: tb/tb_data_mem_stall.sv
// Directed bench for data_mem_stall at LATENCY=4 (dut_a) and LATENCY=1 (dut_b).
// Latency: n/a.
// Backpressure: n/a.
module tb_data_mem_stall;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nbad = 0;

    always #5 clk = ~clk;

    data_mem_stall_if ifa ();
    data_mem_stall_if ifb ();

    data_mem_stall #(.ADDR_W(8), .LATENCY(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    data_mem_stall #(.ADDR_W(8), .LATENCY(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    task automatic drive(input bit sel, input logic en, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        if (sel) begin
            ifb.enable = en; ifb.wr = w; ifb.addr = a; ifb.data_in = d;
        end else begin
            ifa.enable = en; ifa.wr = w; ifa.addr = a; ifa.data_in = d;
        end
    endtask

    // Present one request for one edge, then count cycles until done (bounded).
    // lat stays -1 if done never arrives.
    task automatic do_req(input bit sel, input logic w, input logic [15:0] a, input logic [15:0] d,
                          output int lat, output int stalls, output logic [15:0] dout, output logic e);
        bit seen;
        lat = -1; stalls = 0; dout = 16'hxxxx; e = 1'bx; seen = 0;
        drive(sel, 1'b1, w, a, d);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if ((sel ? ifb.stall : ifa.stall) === 1'b1) stalls++;
            if ((sel ? ifb.done : ifa.done) === 1'b1) begin
                seen = 1; lat = i;
                dout = sel ? ifb.data_out : ifa.data_out;
                e    = sel ? ifb.err : ifa.err;
            end
        end
    endtask

    task automatic test_reset;
        drive(0, 0, 0, 16'h0, 16'h0);
        drive(1, 0, 0, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        nchk++; if ({ifa.done, ifa.stall, ifa.err, ifa.data_out} !== 19'h0) begin nbad++; $display("FAIL reset_a got=%h want=0", {ifa.done, ifa.stall, ifa.err, ifa.data_out}); end
        nchk++; if ({ifb.done, ifb.stall, ifb.err, ifb.data_out} !== 19'h0) begin nbad++; $display("FAIL reset_b got=%h want=0", {ifb.done, ifb.stall, ifb.err, ifb.data_out}); end
        rst = 1'b0;
    endtask

    task automatic test_write_read;
        int lat, st; logic [15:0] dv; logic e;
        do_req(0, 1, 16'h0010, 16'hBEEF, lat, st, dv, e);
        nchk++; if (lat !== 4)        begin nbad++; $display("FAIL wr_lat got=%0d want=4", lat); end
        nchk++; if (st !== 3)         begin nbad++; $display("FAIL wr_stall got=%0d want=3", st); end
        nchk++; if (e !== 1'b0)       begin nbad++; $display("FAIL wr_err got=%b want=0", e); end
        nchk++; if (dv !== 16'h0000)  begin nbad++; $display("FAIL wr_dout got=%h want=0000", dv); end
        do_req(0, 0, 16'h0010, 16'h0000, lat, st, dv, e);
        nchk++; if (lat !== 4)        begin nbad++; $display("FAIL rd_lat got=%0d want=4", lat); end
        nchk++; if (dv !== 16'hBEEF)  begin nbad++; $display("FAIL rd_dout got=%h want=beef", dv); end
        nchk++; if (e !== 1'b0)       begin nbad++; $display("FAIL rd_err got=%b want=0", e); end
        @(negedge clk);
        nchk++; if ({ifa.done, ifa.stall, ifa.data_out} !== 18'h0) begin nbad++; $display("FAIL idle_outs got=%h want=0", {ifa.done, ifa.stall, ifa.data_out}); end
    endtask

    task automatic test_misaligned;
        int lat, st; logic [15:0] dv; logic e;
        do_req(0, 0, 16'h0011, 16'h0000, lat, st, dv, e);
        nchk++; if (lat !== 1)        begin nbad++; $display("FAIL mis_lat got=%0d want=1", lat); end
        nchk++; if (e !== 1'b1)       begin nbad++; $display("FAIL mis_err got=%b want=1", e); end
        nchk++; if (dv !== 16'h0000)  begin nbad++; $display("FAIL mis_dout got=%h want=0000", dv); end
        nchk++; if (st !== 0)         begin nbad++; $display("FAIL mis_stall got=%0d want=0", st); end
        // Misaligned write must not touch the array.
        do_req(0, 1, 16'h0011, 16'h1111, lat, st, dv, e);
        do_req(0, 0, 16'h0010, 16'h0000, lat, st, dv, e);
        nchk++; if (dv !== 16'hBEEF)  begin nbad++; $display("FAIL mis_prior got=%h want=beef", dv); end
    endtask

    task automatic test_back_to_back;
        int lat, st, nd; logic [15:0] dv; logic e;
        do_req(0, 1, 16'h0020, 16'h1234, lat, st, dv, e);
        // Still in the write's DONE cycle: the read is accepted at the next edge.
        do_req(0, 0, 16'h0020, 16'h0000, lat, st, dv, e);
        nchk++; if (lat !== 4)        begin nbad++; $display("FAIL b2b_lat got=%0d want=4", lat); end
        nchk++; if (dv !== 16'h1234)  begin nbad++; $display("FAIL b2b_dout got=%h want=1234", dv); end
        nd = 0;
        repeat (6) begin @(negedge clk); if (ifa.done === 1'b1) nd++; end
        nchk++; if (nd !== 0)         begin nbad++; $display("FAIL b2b_extra_done got=%0d want=0", nd); end
    endtask

    task automatic test_ignore_busy;
        int lat, st, cyc; logic [15:0] dv; logic e; bit seen;
        do_req(0, 1, 16'h0040, 16'h0101, lat, st, dv, e);
        @(negedge clk);
        drive(0, 1, 0, 16'h0010, 16'h0);
        @(posedge clk); #1;                               // accepted
        drive(0, 1, 1, 16'h0040, 16'hDEAD);
        @(posedge clk); #1; drive(0, 0, 1, 16'h0042, 16'hDEAD);
        @(posedge clk); #1; drive(0, 1, 0, 16'h0011, 16'h0);
        @(posedge clk); #1; drive(0, 0, 0, 16'h0, 16'h0);
        seen = 0; cyc = 0; dv = 16'hxxxx;
        for (int i = 1; i <= 10 && !seen; i++) begin
            @(negedge clk);
            if (ifa.done === 1'b1) begin seen = 1; cyc = i; dv = ifa.data_out; end
        end
        nchk++; if (cyc !== 1)        begin nbad++; $display("FAIL ign_lat got=%0d want=1", cyc); end
        nchk++; if (dv !== 16'hBEEF)  begin nbad++; $display("FAIL ign_dout got=%h want=beef", dv); end
        do_req(0, 0, 16'h0040, 16'h0000, lat, st, dv, e);
        nchk++; if (dv !== 16'h0101)  begin nbad++; $display("FAIL ign_nowrite got=%h want=0101", dv); end
    endtask

    task automatic test_reset_mid_write;
        int lat, st; logic [15:0] dv; logic e;
        do_req(0, 1, 16'h0030, 16'h5555, lat, st, dv, e);
        @(negedge clk);
        drive(0, 1, 1, 16'h0030, 16'hAAAA);
        @(posedge clk); #1; drive(0, 0, 0, 16'h0, 16'h0);
        @(posedge clk); #1;
        nchk++; if (ifa.stall !== 1'b1) begin nbad++; $display("FAIL rstw_busy got=%b want=1", ifa.stall); end
        rst = 1'b1; #1;
        nchk++; if ({ifa.done, ifa.stall, ifa.err, ifa.data_out} !== 19'h0) begin nbad++; $display("FAIL rstw_outs got=%h want=0", {ifa.done, ifa.stall, ifa.err, ifa.data_out}); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        do_req(0, 0, 16'h0030, 16'h0000, lat, st, dv, e);
        nchk++; if (dv !== 16'h5555)  begin nbad++; $display("FAIL rstw_keep got=%h want=5555", dv); end
        nchk++; if (lat !== 4)        begin nbad++; $display("FAIL rstw_lat got=%0d want=4", lat); end
    endtask

    task automatic test_alias;
        int lat, st; logic [15:0] dv; logic e;
        do_req(0, 1, 16'h0202, 16'h7777, lat, st, dv, e);
        do_req(0, 0, 16'h0002, 16'h0000, lat, st, dv, e);
        nchk++; if (dv !== 16'h7777)  begin nbad++; $display("FAIL alias got=%h want=7777", dv); end
    endtask

    task automatic test_latency1;
        int lat, st; logic [15:0] dv; logic e;
        do_req(1, 1, 16'h0008, 16'h4321, lat, st, dv, e);
        nchk++; if (lat !== 1)        begin nbad++; $display("FAIL l1_wr_lat got=%0d want=1", lat); end
        nchk++; if (st !== 0)         begin nbad++; $display("FAIL l1_stall got=%0d want=0", st); end
        nchk++; if (dv !== 16'h0000)  begin nbad++; $display("FAIL l1_wr_dout got=%h want=0000", dv); end
        do_req(1, 0, 16'h0008, 16'h0000, lat, st, dv, e);
        nchk++; if (lat !== 1)        begin nbad++; $display("FAIL l1_rd_lat got=%0d want=1", lat); end
        nchk++; if (dv !== 16'h4321)  begin nbad++; $display("FAIL l1_rd_dout got=%h want=4321", dv); end
        do_req(1, 0, 16'h0009, 16'h0000, lat, st, dv, e);
        nchk++; if (e !== 1'b1)       begin nbad++; $display("FAIL l1_mis_err got=%b want=1", e); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_misaligned;
        test_back_to_back;
        test_ignore_busy;
        test_reset_mid_write;
        test_alias;
        test_latency1;
        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
